// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_controller_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQUEST = 2'd1,
        FETCH_HOLD    = 2'd2
    } fetch_state_t;

    localparam int          INSTRUCTION_WIDTH        = 32;
    localparam logic [31:0] PC_STEP                  = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR     = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXCEPTION_VECTOR = 32'h0000_0020;

    // Sequential successor; the add wraps at 32 bits (FFFF_FFFC -> 0).
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Output register plus one skid entry between instruction memory and decode.
// Holds every fetched word so a stalled decode never loses or duplicates one.
module fetch_skid_buffer
    import fetch_controller_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [INSTRUCTION_WIDTH-1:0] push_data,
    input  logic [31:0]                  push_pc,
    input  logic                         pop,
    output logic [INSTRUCTION_WIDTH-1:0] out_data,
    output logic [31:0]                  out_pc,
    output logic                         out_valid,
    output logic                         skid_full
);

    logic [INSTRUCTION_WIDTH-1:0] skid_data;
    logic [31:0]                  skid_pc;
    logic                         consume;

    assign consume = out_valid && pop;

    // Output fills first; skid only catches a word arriving while output is held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_pc    <= '0;
            out_valid <= 1'b0;
            skid_data <= '0;
            skid_pc   <= '0;
            skid_full <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (skid_full) begin
            if (consume) begin
                out_data  <= skid_data;
                out_pc    <= skid_pc;
                out_valid <= 1'b1;
                skid_full <= push;
                if (push) begin
                    skid_data <= push_data;
                    skid_pc   <= push_pc;
                end
            end
        end else if (push) begin
            if (!out_valid || consume) begin
                out_data  <= push_data;
                out_pc    <= push_pc;
                out_valid <= 1'b1;
            end else begin
                skid_data <= push_data;
                skid_pc   <= push_pc;
                skid_full <= 1'b1;
            end
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC, memory handshake FSM and redirect handling.
// Optional feature macro: FETCH_EXCEPTION_EN adds exception_enable, which
// redirects to EXCEPTION_VECTOR ahead of any branch.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
`ifdef FETCH_EXCEPTION_EN
    , parameter logic [31:0] EXCEPTION_VECTOR = DEFAULT_EXCEPTION_VECTOR
`endif
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         branch_enable,
    input  logic [31:0]                  branch_target,
`ifdef FETCH_EXCEPTION_EN
    input  logic                         exception_enable,
`endif
    output logic                         imem_request,
    output logic [31:0]                  imem_address,
    input  logic                         imem_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
    output logic [31:0]                  register_pc,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [31:0]                  instruction_pc,
    output logic                         instruction_valid
);

    fetch_state_t state;
    logic [31:0]  redirect_target;
    logic         redirect_pending;
    logic         redirect;
    logic [31:0]  target;
    logic         completion;
    logic         consume;
    logic         push;
    logic         skid_full;
    logic         skid_full_next;

    // Redirect source selection: exception outranks branch.
    always_comb begin
`ifdef FETCH_EXCEPTION_EN
        redirect = exception_enable || branch_enable;
        target   = exception_enable ? EXCEPTION_VECTOR : branch_target;
`else
        redirect = branch_enable;
        target   = branch_target;
`endif
    end

    assign imem_request = (state == FETCH_REQUEST);
    assign imem_address = register_pc;
    assign completion   = (state == FETCH_REQUEST) && imem_ready;
    assign consume      = instruction_valid && !stall;
    // A word fetched from a stale PC (redirect now or pending) is dropped.
    assign push         = completion && !redirect && !redirect_pending;

    // Skid occupancy after this edge, ignoring flush (flush only ever empties it).
    assign skid_full_next = skid_full ? (!consume || push)
                                      : (push && instruction_valid && !consume);

    // Fetch FSM, PC and deferred-redirect bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= FETCH_IDLE;
            register_pc      <= RESET_VECTOR;
            redirect_target  <= '0;
            redirect_pending <= 1'b0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (redirect) register_pc <= target;
                    state <= FETCH_REQUEST;
                end
                FETCH_REQUEST: begin
                    if (completion) begin
                        redirect_pending <= 1'b0;
                        if (redirect)              register_pc <= target;
                        else if (redirect_pending) register_pc <= redirect_target;
                        else                       register_pc <= next_pc(register_pc);
                        state <= (skid_full_next && !redirect) ? FETCH_HOLD : FETCH_REQUEST;
                    end else if (redirect) begin
                        // Address already on the bus must stay stable; apply later.
                        redirect_target  <= target;
                        redirect_pending <= 1'b1;
                    end
                end
                FETCH_HOLD: begin
                    if (redirect) begin
                        register_pc <= target;
                        state       <= FETCH_REQUEST;
                    end else if (!skid_full_next) begin
                        state <= FETCH_REQUEST;
                    end
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

    fetch_skid_buffer u_skid (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data (imem_data),
        .push_pc   (register_pc),
        .pop       (!stall),
        .out_data  (instruction),
        .out_pc    (instruction_pc),
        .out_valid (instruction_valid),
        .skid_full (skid_full)
    );

endmodule
